fetch_mem_arbiter: RTL and testbench

Sits directly upstream of the 1024x16 main memory (combinational read, write on posedge when w_en) and owns its addr/w_en/d_in pins. Streams instruction words from a program counter into a small prefetch FIFO that feeds decode over a valid/ready handshake. Grants single-cycle data load/store accesses from execute, with priority over fetch. Handles branch redirect by flushing the FIFO and reloading the PC.

---
 rtl/fetch_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_fetch_mem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter
//   Owns the address/write pins of a single-port main memory (combinational
//   read, write on posedge). Streams instruction words from a program counter
//   into a small prefetch FIFO feeding decode (valid/ready), grants zero-latency
//   data load/store accesses from execute with priority over fetch, and handles
//   branch redirects by flushing the FIFO and reloading the PC.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mem_addr/mem_w_en/mem_d_in    memory address, write enable, write data
//   mem_d_out                     memory combinational read data
//   instr_valid/ready/data/pc     prefetch FIFO head towards decode
//   redirect_valid/redirect_pc    branch taken: flush FIFO, load new PC
//   dreq_valid/we/addr/wdata      data access request from execute
//   dreq_grant/dreq_rdata         access performed this cycle, load data
//
// Optional feature (macro FETCH_STATS_EN):
//   stat_fetches  count of FIFO pushes (saturating 16 bit)
//   stat_dstalls  cycles a fetch was possible but blocked by a data access
module fetch_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 16,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_w_en,
  output logic [WORD_W-1:0] mem_d_in,
  input  logic [WORD_W-1:0] mem_d_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [WORD_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              dreq_valid,
  input  logic              dreq_we,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [WORD_W-1:0] dreq_wdata,
  output logic              dreq_grant,
  output logic [WORD_W-1:0] dreq_rdata
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]       stat_fetches,
  output logic [15:0]       stat_dstalls
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
  logic [WORD_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;

  logic full;
  logic grant;
  logic fetch;
  logic pop;

  // A full FIFO never fetches, even when a pop frees a slot this same cycle;
  // this keeps the fetch decision independent of decode's ready.
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign grant = dreq_valid & ~rst;
  assign fetch = ~rst & ~dreq_valid & ~redirect_valid & ~full;
  assign pop   = instr_valid & instr_ready;

  // Data accesses own the memory port whenever requested; otherwise it reads at pc.
  assign mem_addr   = grant ? dreq_addr : pc;
  assign mem_w_en   = grant & dreq_we;
  assign mem_d_in   = dreq_wdata;
  assign dreq_grant = grant;
  assign dreq_rdata = mem_d_out;

  // Head entry comes straight from the FIFO storage registers.
  assign instr_valid = (count != CNT_W'(0));
  assign instr_data  = fifo_data[rptr];
  assign instr_pc    = fifo_pc[rptr];

  // FIFO storage: capture {pc, word} on each fetch (fetch already excludes rst/redirect).
  always_ff @(posedge clk) begin
    if (fetch) begin
      fifo_pc[wptr]   <= pc;
      fifo_data[wptr] <= mem_d_out;
    end
  end

  // PC, pointers and occupancy; redirect flushes and discards any same-cycle pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      pc    <= redirect_pc;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (fetch) begin
        wptr <= wptr + PTR_W'(1);
        pc   <= pc + ADDR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      case ({fetch, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic dstall;

  // A data stall is a cycle that would have fetched had dreq_valid been low.
  assign dstall = ~rst & dreq_valid & ~redirect_valid & ~full;

  // Saturating statistics counters; redirect does not touch them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetches <= 16'h0000;
      stat_dstalls <= 16'h0000;
    end else begin
      if (fetch && stat_fetches != 16'hFFFF) begin
        stat_fetches <= stat_fetches + 16'h0001;
      end
      if (dstall && stat_dstalls != 16'hFFFF) begin
        stat_dstalls <= stat_dstalls + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed self-checking bench for fetch_mem_arbiter with a 1024x16 memory model.
module tb_fetch_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [9:0]  mem_addr;
  logic        mem_w_en;
  logic [15:0] mem_d_in;
  logic [15:0] mem_d_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic [9:0]  instr_pc;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        dreq_valid;
  logic        dreq_we;
  logic [9:0]  dreq_addr;
  logic [15:0] dreq_wdata;
  logic        dreq_grant;
  logic [15:0] dreq_rdata;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetches;
  logic [15:0] stat_dstalls;
`endif

  logic [15:0] mem [1024];
  logic        preload;
  int          vectors;
  int          errors;

  fetch_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_w_en(mem_w_en), .mem_d_in(mem_d_in), .mem_d_out(mem_d_out),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dreq_valid(dreq_valid), .dreq_we(dreq_we), .dreq_addr(dreq_addr),
    .dreq_wdata(dreq_wdata), .dreq_grant(dreq_grant), .dreq_rdata(dreq_rdata)
`ifdef FETCH_STATS_EN
    , .stat_fetches(stat_fetches), .stat_dstalls(stat_dstalls)
`endif
  );

  // Initial memory image: words 0..3 fixed, others derived from the address.
  function automatic logic [15:0] word(input logic [9:0] a);
    if (a < 10'd4) word = 16'h1111 * ({6'd0, a} + 16'd1);
    else           word = 16'h5000 ^ {6'd0, a};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: preload on request, else write on posedge when enabled.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= word(10'(i));
    end else if (mem_w_en) begin
      mem[mem_addr] <= mem_d_in;
    end
  end

  assign mem_d_out = mem[mem_addr];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input logic [9:0] k);
    chk("head_valid", 32'(instr_valid), 32'd1);
    chk("head_pc", 32'(instr_pc), 32'(k));
    chk("head_data", 32'(instr_data), 32'(word(k)));
  endtask

  initial begin
    vectors = 0;
    errors = 0;
    rst = 1'b1;
    preload = 1'b1;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 10'd0;
    dreq_valid = 1'b0;
    dreq_we = 1'b0;
    dreq_addr = 10'd0;
    dreq_wdata = 16'd0;
    step();
    preload = 1'b0;
    step();
    chk("reset_valid", 32'(instr_valid), 32'd0);

    // Store request while in reset must be ignored.
    dreq_valid = 1'b1; dreq_we = 1'b1; dreq_addr = 10'd5; dreq_wdata = 16'hFFFF;
    #1;
    chk("reset_wen", 32'(mem_w_en), 32'd0);
    chk("reset_grant", 32'(dreq_grant), 32'd0);
    step();
    chk("reset_mem", 32'(mem[5]), 32'(word(10'd5)));

    // Streaming: valid one posedge after release, consecutive words.
    dreq_valid = 1'b0; dreq_we = 1'b0; rst = 1'b0; instr_ready = 1'b1;
    #1;
    chk("first_valid_pre", 32'(instr_valid), 32'd0);
    step();
    pop_check(10'd0);
    for (int k = 1; k < 4; k++) begin
      step();
      pop_check(10'(k));
    end

    // Flush to pc 0 and let the FIFO fill with decode stalled.
    redirect_valid = 1'b1; redirect_pc = 10'd0; instr_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    chk("flush_valid", 32'(instr_valid), 32'd0);
    repeat (6) step();
    pop_check(10'd0);
    #1;
    chk("full_pc_hold", 32'(mem_addr), 32'd4);
    chk("full_wen", 32'(mem_w_en), 32'd0);
    instr_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      step();
      pop_check(10'(k));
    end

    // Store then load at 0x200; pc (10) must not advance.
    dreq_valid = 1'b1; dreq_we = 1'b1; dreq_addr = 10'h200; dreq_wdata = 16'hBEEF;
    #1;
    chk("st_addr", 32'(mem_addr), 32'h200);
    chk("st_wen", 32'(mem_w_en), 32'd1);
    chk("st_grant", 32'(dreq_grant), 32'd1);
    step();
    pop_check(10'd8);
    dreq_we = 1'b0;
    #1;
    chk("ld_rdata", 32'(dreq_rdata), 32'hBEEF);
    chk("ld_grant", 32'(dreq_grant), 32'd1);
    chk("ld_wen", 32'(mem_w_en), 32'd0);
    step();
    pop_check(10'd9);
    dreq_valid = 1'b0;
    #1;
    chk("dreq_pc_hold", 32'(mem_addr), 32'd10);

    // Three entries held, then redirect to 0x3FF with a discarded pop.
    instr_ready = 1'b0;
    step();
    step();
    redirect_valid = 1'b1; redirect_pc = 10'h3FF; instr_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("redir_valid", 32'(instr_valid), 32'd0);
    step();
    pop_check(10'h3FF);
    step();
    pop_check(10'h000);

    // Reset mid-stream with a store pending.
    rst = 1'b1; dreq_valid = 1'b1; dreq_we = 1'b1; dreq_addr = 10'h100; dreq_wdata = 16'hDEAD;
    #1;
    chk("rst2_wen", 32'(mem_w_en), 32'd0);
    chk("rst2_grant", 32'(dreq_grant), 32'd0);
    step();
    chk("rst2_valid", 32'(instr_valid), 32'd0);
    rst = 1'b0; dreq_valid = 1'b0; dreq_we = 1'b0;
    #1;
    chk("rst2_mem", 32'(mem[10'h100]), 32'(word(10'h100)));
    step();
    pop_check(10'd0);

`ifdef FETCH_STATS_EN
    rst = 1'b1;
    step();
    chk("stat_f_rst", 32'(stat_fetches), 32'd0);
    chk("stat_d_rst", 32'(stat_dstalls), 32'd0);
    rst = 1'b0;
    repeat (5) step();
    dreq_valid = 1'b1; dreq_addr = 10'd7;
    repeat (3) step();
    dreq_valid = 1'b0;
    repeat (5) step();
    chk("stat_fetches", 32'(stat_fetches), 32'd10);
    chk("stat_dstalls", 32'(stat_dstalls), 32'd3);
    rst = 1'b1;
    step();
    chk("stat_f_clr", 32'(stat_fetches), 32'd0);
    chk("stat_d_clr", 32'(stat_dstalls), 32'd0);
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
